// File: rtl/fp_converter_sequencer.sv
// fp_converter_sequencer
//
// Sits between the FP issue stage and the FpConverter datapath. It accepts
// one conversion request at a time and resolves a dynamic rounding mode
// from frm. It holds the operands on the converter for LATENCY cycles,
// then captures the converter result, flags and tag and returns them as a
// response. Illegal rounding modes are answered at once with respIllegal
// and all-zero results. flush drops whatever is in flight.
//
// Handshakes: a transfer happens on a rising edge where valid && ready
// were both high in the preceding cycle. While valid is high the sender
// keeps its payload stable. ready never depends combinationally on the
// same channel's valid.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             drop in-flight request and pending response
//   frm               fcsr.frm, used when reqRoundingMode is DYN (3'b111)
//   req*              request channel (valid/ready, command, rm, operands, tag)
//   cvt* (out)        registered operands held on the converter
//   cvt* (in)         converter int/fp results and flags
//   resp*             response channel (valid/ready, results, flags, tag, illegal)
//   busy              sequencer not idle
//   state_dbg         current FSM state (0 IDLE, 1 EXEC, 2 DONE)
//
// Flags are ordered {NV, DZ, OF, UF, NX} from bit 4 down to bit 0.

module fp_converter_sequencer #(
  parameter int LATENCY = 2,   // cycles operands are held, 1..15
  parameter int TAG_W   = 4,
  parameter int CMD_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [2:0]       frm,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [CMD_W-1:0] reqCommand,
  input  logic [2:0]       reqRoundingMode,
  input  logic [31:0]      reqIntSrc,
  input  logic [63:0]      reqFpSrc,
  input  logic [TAG_W-1:0] reqTag,
  output logic [CMD_W-1:0] cvtCommand,
  output logic [2:0]       cvtRoundingMode,
  output logic [31:0]      cvtIntSrc,
  output logic [63:0]      cvtFpSrc,
  input  logic [31:0]      cvtIntResult,
  input  logic [63:0]      cvtFpResult,
  input  logic [4:0]       cvtFlags,
  output logic             respValid,
  input  logic             respReady,
  output logic [31:0]      respIntResult,
  output logic [63:0]      respFpResult,
  output logic [4:0]       respFlags,
  output logic [TAG_W-1:0] respTag,
  output logic             respIllegal,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] count;

  logic [2:0] rm_resolved;
  logic       rm_illegal;
  logic       accept;

  // DYN selects frm; 101/110/111 are reserved encodings after resolution.
  assign rm_resolved = (reqRoundingMode == 3'b111) ? frm : reqRoundingMode;
  assign rm_illegal  = rm_resolved[2] & (rm_resolved[1] | rm_resolved[0]);

  // Ready depends only on state, respReady and flush. In DONE a new request
  // can only enter in the cycle the current response retires.
  assign reqReady  = !flush && ((state == IDLE) || ((state == DONE) && respReady));
  assign accept    = reqValid && reqReady;

  assign respValid = (state == DONE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      cvtCommand      <= '0;
      cvtRoundingMode <= '0;
      cvtIntSrc       <= '0;
      cvtFpSrc        <= '0;
      respIntResult   <= '0;
      respFpResult    <= '0;
      respFlags       <= '0;
      respTag         <= '0;
      respIllegal     <= 1'b0;
    end else if (flush) begin
      // Pending response simply disappears; data registers are left alone.
      state <= IDLE;
    end else if (accept) begin
      // Covers both a fresh start from IDLE and back-to-back from DONE.
      respTag <= reqTag;
      if (rm_illegal) begin
        // The converter never sees an illegal request: cvt* keep old values.
        respIntResult <= '0;
        respFpResult  <= '0;
        respFlags     <= '0;
        respIllegal   <= 1'b1;
        state         <= DONE;
      end else begin
        cvtCommand      <= reqCommand;
        cvtRoundingMode <= rm_resolved;
        cvtIntSrc       <= reqIntSrc;
        cvtFpSrc        <= reqFpSrc;
        count           <= 4'(LATENCY - 1);
        respIllegal     <= 1'b0;
        state           <= EXEC;
      end
    end else begin
      case (state)
        EXEC: begin
          if (count == 4'd0) begin
            respIntResult <= cvtIntResult;
            respFpResult  <= cvtFpResult;
            respFlags     <= cvtFlags;
            state         <= DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE: begin
          if (respReady) state <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
